// File: rtl/mod_counter_pkg.sv
// Shared encodings for the modulo up/down counter.
// Sequencers drive up_dn and sat_mode through these names instead of
// bare literals.
package mod_counter_pkg;

  // Direction encoding for up_dn.
  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  // Bound behaviour encoding for sat_mode.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler: divides enabled cycles down to count steps.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (prescaler -> 0)
//   enable   advance the prescaler this cycle
//   sync_clr synchronous clear of the prescaler (wins over enable)
//   step     high on the enabled cycle that completes PRESCALE enables
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic sync_clr,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // Every enabled cycle is a step; no state is needed.
      logic unused_inputs;
      assign unused_inputs = &{1'b0, clk, reset_n, sync_clr};
      assign step = enable;
    end else begin : g_div
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] pcnt;

      assign step = enable && (pcnt == LAST);

      // Holds while enable is low, so a gap stretches the step by one cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pcnt <= '0;
        end else if (sync_clr) begin
          pcnt <= '0;
        end else if (enable) begin
          pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
        end
      end
    end
  endgenerate

endmodule : tick_prescaler

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo up/down counter with prescaler.
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   enable     advance prescaler / counter
//   up_dn      DIR_UP counts up, DIR_DOWN counts down
//   sat_mode   MODE_SAT holds at the bounds, MODE_WRAP wraps modulo MODULUS
//   clear      synchronous clear of count, prescaler, wrap and ovf
//   load       synchronous load of min(load_value, MODULUS-1)
//   load_value value to load
//   ovf_clr    clear sticky ovf (an overflow on the same edge wins)
//   count      registered count, always within 0..MODULUS-1
//   tc         combinational terminal count in the current direction
//   wrap       registered one-cycle pulse alongside the wrapped count
//   ovf        registered sticky overflow/underflow flag
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  // Load clamp done one bit wider so load_value values above MODULUS-1
  // (possible when MODULUS is not a power of two) compare correctly.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] vx;
    logic [WIDTH:0] mx;
    vx = {1'b0, v};
    mx = {1'b0, MAX_CNT};
    return (vx > mx) ? MAX_CNT : v;
  endfunction

  logic             step;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_evt;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .sync_clr (clear || load),
    .step     (step)
  );

  assign tc = ((up_dn == DIR_UP)   && (count == MAX_CNT)) ||
              ((up_dn == DIR_DOWN) && (count == '0));

  // Next-count: clear > load > step. Increment/decrement only happen
  // strictly inside the range, so they can never leave 0..MODULUS-1.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_evt   = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = clamp_load(load_value);
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (count == MAX_CNT) begin
          ovf_evt = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count + WIDTH'(1);
        end
      end else begin
        if (count == '0) begin
          ovf_evt = 1'b1;
          if (sat_mode == MODE_WRAP) begin
            count_nxt = MAX_CNT;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      if (clear) begin
        ovf <= 1'b0;
      end else if (ovf_evt) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       up_dn;
  logic       sat_mode;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       ovf_clr;

  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, wrap_a, wrap_b, ovf_a, ovf_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .clear(clear), .load(load), .load_value(load_value),
    .ovf_clr(ovf_clr), .count(count_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
  );

  mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
    .sat_mode(sat_mode), .clear(clear), .load(load), .load_value(load_value),
    .ovf_clr(ovf_clr), .count(count_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic en_pat [9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int   cnt_pat [9] = '{0, 0, 1, 1, 1, 1, 2, 2, 2};

  initial begin
    reset_n = 1'b0; enable = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = 4'd0; ovf_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_count", 32'(count_a), 0);
    chk("rst_wrap",  32'(wrap_a), 0);
    chk("rst_ovf",   32'(ovf_a), 0);
    chk("rst_tc",    32'(tc_a), 0);
    reset_n = 1'b1;

    // 1: up count in wrap mode, 0..9 then 0, 1
    enable = 1'b1;
    chk("t1_c0", 32'(count_a), 0);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk($sformatf("t1_count_%0d", k), 32'(count_a), 32'(k % 10));
      chk($sformatf("t1_wrap_%0d", k),  32'(wrap_a),  32'(k == 10));
      chk($sformatf("t1_ovf_%0d", k),   32'(ovf_a),   32'(k >= 10));
      chk($sformatf("t1_tc_%0d", k),    32'(tc_a),    32'(k == 9));
    end

    // 2: down from 0 in wrap mode, then ovf_clr
    enable = 1'b0; load = 1'b1; load_value = 4'd0;
    tick();
    load = 1'b0;
    chk("t2_load0", 32'(count_a), 0);
    chk("t2_ovf_kept", 32'(ovf_a), 1);
    up_dn = 1'b0;
    #1 chk("t2_tc_down0", 32'(tc_a), 1);
    chk("t2_tc_up_follow", 32'(dut_a.tc), 1);
    enable = 1'b1;
    tick();
    chk("t2_count9", 32'(count_a), 9);
    chk("t2_wrap1", 32'(wrap_a), 1);
    tick();
    chk("t2_count8", 32'(count_a), 8);
    chk("t2_wrap0", 32'(wrap_a), 0);
    enable = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", 32'(ovf_a), 0);

    // 3: saturate mode at both bounds
    sat_mode = 1'b1; up_dn = 1'b1; load = 1'b1; load_value = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t3_hold9_%0d", k), 32'(count_a), 9);
      chk($sformatf("t3_wrap_%0d", k),  32'(wrap_a), 0);
      chk($sformatf("t3_ovf_%0d", k),   32'(ovf_a), 1);
    end
    chk("t3_tc9", 32'(tc_a), 1);
    enable = 1'b0; load = 1'b1; load_value = 4'd0; ovf_clr = 1'b1;
    tick();
    load = 1'b0; ovf_clr = 1'b0;
    chk("t3_ovf_cleared", 32'(ovf_a), 0);
    up_dn = 1'b0; enable = 1'b1; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_hold0", 32'(count_a), 0);
    chk("t3_set_beats_clr", 32'(ovf_a), 1);
    chk("t3_wrap_down", 32'(wrap_a), 0);

    // 4: load, clamp, priority
    sat_mode = 1'b0; up_dn = 1'b1; enable = 1'b0; load = 1'b1; load_value = 4'd7;
    tick();
    chk("t4_load7", 32'(count_a), 7);
    load = 1'b0; enable = 1'b1;
    tick();
    chk("t4_step8", 32'(count_a), 8);
    enable = 1'b0; load = 1'b1; load_value = 4'd12;
    tick();
    chk("t4_clamp", 32'(count_a), 9);
    clear = 1'b1; load = 1'b1; enable = 1'b1; load_value = 4'd5;
    tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    chk("t4_clear_pri", 32'(count_a), 0);
    chk("t4_clear_ovf", 32'(ovf_a), 0);
    chk("t4_clear_b", 32'(count_b), 0);

    // 5: PRESCALE = 3 with one enable gap
    up_dn = 1'b1;
    for (int k = 0; k < 9; k++) begin
      enable = en_pat[k];
      tick();
      chk($sformatf("t5_count_%0d", k), 32'(count_b), 32'(cnt_pat[k]));
    end
    enable = 1'b0;

    // 6: asynchronous reset mid-count
    load = 1'b1; load_value = 4'd9;
    tick();
    load = 1'b0; enable = 1'b1;
    tick();
    chk("t6_wrap_pre", 32'(wrap_a), 1);
    enable = 1'b0; load = 1'b1; load_value = 4'd6;
    tick();
    load = 1'b0;
    chk("t6_count6", 32'(count_a), 6);
    chk("t6_ovf_pre", 32'(ovf_a), 1);
    chk("t6_wrap_after_load", 32'(wrap_a), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_count", 32'(count_a), 0);
    chk("t6_async_ovf", 32'(ovf_a), 0);
    chk("t6_async_wrap", 32'(wrap_a), 0);
    tick();
    reset_n = 1'b1; enable = 1'b1;
    tick();
    chk("t6_resume", 32'(count_a), 1);
    tick();
    chk("t6_resume2", 32'(count_a), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mod_counter
